// File: rtl/mips_pipe_pkg.sv
// Shared encodings for the MIPS pipeline memory/write-back slice.
package mips_pipe_pkg;

    // Write-back source select (2'b11 is treated as ALU)
    localparam logic [1:0] MTR_ALU = 2'b00;
    localparam logic [1:0] MTR_MEM = 2'b01;
    localparam logic [1:0] MTR_PC4 = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Data-memory handshake states
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

endpackage

// File: rtl/mem_access_fsm.sv
// Data-memory wait-state FSM: tracks an outstanding access, raises the
// pipeline stall while memory is not ready and counts stalled cycles.
module mem_access_fsm
    import mips_pipe_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   mem_req,
    input  logic                   mem_ready,
    output logic                   mem_stall,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

    mem_state_t state;
    mem_state_t state_next;

    // Stall is combinational so PC, IF/ID and ID/EX freeze in the same cycle.
    assign mem_stall = mem_req & ~mem_ready;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge value regardless of block order.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a same-cycle Ready in IDLE is a zero-wait access.
    always_comb begin
        // NOTE: default assigned first so no path leaves state_next
        // unassigned, which would otherwise infer a latch.
        state_next = state;
        case (state)
            IDLE:    if (mem_req && !mem_ready) state_next = WAIT;
            WAIT:    if (mem_ready || !mem_req) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (mem_stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
        end
    end

endmodule

// File: rtl/ex_mem_wb_stage.sv
// EX/MEM and MEM/WB pipeline registers with the data-memory port and
// write-back mux. Stalls upstream while memory is busy and feeds bubbles
// into write-back during the wait.
module ex_mem_wb_stage
    import mips_pipe_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   EX_RegWr,
    input  logic [4:0]             EX_RegDst,
    input  logic                   EX_MemRd,
    input  logic                   EX_MemWr,
    input  logic [1:0]             EX_MemToReg,
    input  logic [DATA_W-1:0]      EX_ALUOut,
    input  logic [DATA_W-1:0]      EX_StoreData,
    input  logic [DATA_W-1:0]      EX_PC_plus4,
    input  logic                   EX_Flush,
    output logic                   Mem_Req,
    output logic                   Mem_We,
    output logic [DATA_W-1:0]      Mem_Addr,
    output logic [DATA_W-1:0]      Mem_WData,
    input  logic [DATA_W-1:0]      Mem_RData,
    input  logic                   Mem_Ready,
    output logic                   Mem_Stall,
    output logic                   EX_MEM_RegWr,
    output logic [4:0]             EX_MEM_RegDst,
    output logic [DATA_W-1:0]      EX_MEM_ALUOut,
    output logic                   MEM_WB_RegWr,
    output logic [4:0]             MEM_WB_RegDst,
    output logic [DATA_W-1:0]      MEM_WB_WrData,
    output logic [STALL_CNT_W-1:0] Stall_Cnt
);

    // EX/MEM fields not exported as ports
    logic              em_mem_rd;
    logic              em_mem_wr;
    logic [1:0]        em_mem_to_reg;
    logic [DATA_W-1:0] em_store_data;
    logic [DATA_W-1:0] em_pc_plus4;
    logic [DATA_W-1:0] wb_data;

    // Memory port driven straight from EX/MEM, so it stays stable while held
    // and drops asynchronously with reset.
    assign Mem_Req   = em_mem_rd | em_mem_wr;
    assign Mem_We    = em_mem_wr;
    assign Mem_Addr  = EX_MEM_ALUOut;
    assign Mem_WData = em_store_data;

    mem_access_fsm #(
        .STALL_CNT_W (STALL_CNT_W)
    ) u_fsm (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (Mem_Req),
        .mem_ready (Mem_Ready),
        .mem_stall (Mem_Stall),
        .stall_cnt (Stall_Cnt)
    );

    // EX/MEM register: holds while stalled; a flush captures a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            EX_MEM_RegWr  <= 1'b0;
            EX_MEM_RegDst <= REG_ZERO;
            EX_MEM_ALUOut <= '0;
            em_mem_rd     <= 1'b0;
            em_mem_wr     <= 1'b0;
            em_mem_to_reg <= MTR_ALU;
            em_store_data <= '0;
            em_pc_plus4   <= '0;
        end else if (!Mem_Stall) begin
            EX_MEM_RegWr  <= EX_RegWr & ~EX_Flush;
            EX_MEM_RegDst <= EX_RegDst;
            EX_MEM_ALUOut <= EX_ALUOut;
            em_mem_rd     <= EX_MemRd & ~EX_Flush;
            em_mem_wr     <= EX_MemWr & ~EX_Flush;
            em_mem_to_reg <= EX_MemToReg;
            em_store_data <= EX_StoreData;
            em_pc_plus4   <= EX_PC_plus4;
        end
    end

    // Write-back source select.
    always_comb begin
        wb_data = EX_MEM_ALUOut;
        case (em_mem_to_reg)
            MTR_ALU: wb_data = EX_MEM_ALUOut;
            MTR_MEM: wb_data = Mem_RData;
            MTR_PC4: wb_data = em_pc_plus4;
            default: wb_data = EX_MEM_ALUOut;
        endcase
    end

    // MEM/WB register: loads every cycle, a bubble while memory stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            MEM_WB_RegWr  <= 1'b0;
            MEM_WB_RegDst <= REG_ZERO;
            MEM_WB_WrData <= '0;
        end else if (Mem_Stall) begin
            MEM_WB_RegWr  <= 1'b0;
            MEM_WB_RegDst <= REG_ZERO;
            MEM_WB_WrData <= '0;
        end else begin
            MEM_WB_RegWr  <= EX_MEM_RegWr;
            MEM_WB_RegDst <= EX_MEM_RegDst;
            MEM_WB_WrData <= wb_data;
        end
    end

endmodule

// File: tb/tb_ex_mem_wb_stage.sv
// Self-checking bench for ex_mem_wb_stage: a table of zero-wait pipeline
// vectors followed by hand-written wait-state, flush, reset and
// saturation sequences.
module tb_ex_mem_wb_stage;
    import mips_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_regwr;
    logic [4:0]  ex_dst;
    logic        ex_memrd;
    logic        ex_memwr;
    logic [1:0]  ex_mtr;
    logic [31:0] ex_alu;
    logic [31:0] ex_sdata;
    logic [31:0] ex_pc4;
    logic        ex_flush;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        mem_stall;
    logic        em_regwr;
    logic [4:0]  em_dst;
    logic [31:0] em_alu;
    logic        wb_regwr;
    logic [4:0]  wb_dst;
    logic [31:0] wb_data;
    logic [15:0] stall_cnt;

    int n_pass  = 0;
    int n_total = 0;

    ex_mem_wb_stage dut (
        .clk           (clk),
        .reset         (reset),
        .EX_RegWr      (ex_regwr),
        .EX_RegDst     (ex_dst),
        .EX_MemRd      (ex_memrd),
        .EX_MemWr      (ex_memwr),
        .EX_MemToReg   (ex_mtr),
        .EX_ALUOut     (ex_alu),
        .EX_StoreData  (ex_sdata),
        .EX_PC_plus4   (ex_pc4),
        .EX_Flush      (ex_flush),
        .Mem_Req       (mem_req),
        .Mem_We        (mem_we),
        .Mem_Addr      (mem_addr),
        .Mem_WData     (mem_wdata),
        .Mem_RData     (mem_rdata),
        .Mem_Ready     (mem_ready),
        .Mem_Stall     (mem_stall),
        .EX_MEM_RegWr  (em_regwr),
        .EX_MEM_RegDst (em_dst),
        .EX_MEM_ALUOut (em_alu),
        .MEM_WB_RegWr  (wb_regwr),
        .MEM_WB_RegDst (wb_dst),
        .MEM_WB_WrData (wb_data),
        .Stall_Cnt     (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        // stimulus
        logic        regwr;
        logic [4:0]  dst;
        logic        memrd;
        logic        memwr;
        logic [1:0]  mtr;
        logic [31:0] alu;
        logic [31:0] sdata;
        logic [31:0] pc4;
        logic        flush;
        logic        ready;
        logic [31:0] rdata;
        // expected after the capturing edge
        logic        e_em_regwr;
        logic [4:0]  e_em_dst;
        logic [31:0] e_em_alu;
        logic        e_req;
        logic        e_wb_regwr;
        logic [4:0]  e_wb_dst;
        logic [31:0] e_wb_data;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic regwr, input logic [4:0] dst, input logic memrd,
                         input logic memwr, input logic [1:0] mtr, input logic [31:0] alu,
                         input logic [31:0] sdata, input logic [31:0] pc4, input logic flush);
        ex_regwr = regwr;
        ex_dst   = dst;
        ex_memrd = memrd;
        ex_memwr = memwr;
        ex_mtr   = mtr;
        ex_alu   = alu;
        ex_sdata = sdata;
        ex_pc4   = pc4;
        ex_flush = flush;
    endtask

    task automatic drive_nop();
        drive(1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        // Zero-wait pipeline vectors. Ready/RData in a row serve the
        // instruction already in EX/MEM (the previous row).
        vecs[0] = '{1'b1, 5'd5,  1'b0, 1'b0, 2'b00, 32'h10, 32'h0,  32'h0,   1'b0, 1'b1, 32'h0,
                    1'b1, 5'd5,  32'h10, 1'b0, 1'b0, 5'd0,  32'h0};
        vecs[1] = '{1'b1, 5'd8,  1'b1, 1'b0, 2'b01, 32'h40, 32'h0,  32'h0,   1'b0, 1'b1, 32'h0,
                    1'b1, 5'd8,  32'h40, 1'b1, 1'b1, 5'd5,  32'h10};
        vecs[2] = '{1'b1, 5'd31, 1'b0, 1'b0, 2'b10, 32'h99, 32'h0,  32'h104, 1'b0, 1'b1, 32'hDEADBEEF,
                    1'b1, 5'd31, 32'h99, 1'b0, 1'b1, 5'd8,  32'hDEADBEEF};
        vecs[3] = '{1'b1, 5'd7,  1'b1, 1'b0, 2'b01, 32'h50, 32'h0,  32'h0,   1'b1, 1'b0, 32'h0,
                    1'b0, 5'd7,  32'h50, 1'b0, 1'b1, 5'd31, 32'h104};
        vecs[4] = '{1'b1, 5'd3,  1'b0, 1'b0, 2'b11, 32'h77, 32'h0,  32'h200, 1'b0, 1'b0, 32'h0,
                    1'b1, 5'd3,  32'h77, 1'b0, 1'b0, 5'd0,  32'h0};
        vecs[5] = '{1'b0, 5'd0,  1'b0, 1'b1, 2'b00, 32'h60, 32'hAA, 32'h0,   1'b0, 1'b0, 32'h0,
                    1'b0, 5'd0,  32'h60, 1'b1, 1'b1, 5'd3,  32'h77};
        vecs[6] = '{1'b0, 5'd0,  1'b0, 1'b0, 2'b00, 32'h0,  32'h0,  32'h0,   1'b0, 1'b1, 32'h0,
                    1'b0, 5'd0,  32'h0,  1'b0, 1'b0, 5'd0,  32'h0};

        reset     = 1'b1;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        drive_nop();
        repeat (2) @(posedge clk);
        #1;
        check("rst_req",       {63'd0, mem_req},   64'd0);
        check("rst_em_regwr",  {63'd0, em_regwr},  64'd0);
        check("rst_wb_regwr",  {63'd0, wb_regwr},  64'd0);
        check("rst_wb_data",   {32'd0, wb_data},   64'd0);
        check("rst_stall_cnt", {48'd0, stall_cnt}, 64'd0);
        reset = 1'b0;

        // Table-driven zero-wait pipeline
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].regwr, vecs[i].dst, vecs[i].memrd, vecs[i].memwr, vecs[i].mtr,
                  vecs[i].alu, vecs[i].sdata, vecs[i].pc4, vecs[i].flush);
            mem_ready = vecs[i].ready;
            mem_rdata = vecs[i].rdata;
            #1;
            check($sformatf("v%0d_stall", i), {63'd0, mem_stall}, 64'd0);
            tick();
            check($sformatf("v%0d_em_regwr", i), {63'd0, em_regwr}, {63'd0, vecs[i].e_em_regwr});
            if (vecs[i].e_em_regwr) begin
                check($sformatf("v%0d_em_dst", i), {59'd0, em_dst}, {59'd0, vecs[i].e_em_dst});
                check($sformatf("v%0d_em_alu", i), {32'd0, em_alu}, {32'd0, vecs[i].e_em_alu});
            end
            check($sformatf("v%0d_req", i), {63'd0, mem_req}, {63'd0, vecs[i].e_req});
            check($sformatf("v%0d_wb_regwr", i), {63'd0, wb_regwr}, {63'd0, vecs[i].e_wb_regwr});
            if (vecs[i].e_wb_regwr) begin
                check($sformatf("v%0d_wb_dst", i), {59'd0, wb_dst}, {59'd0, vecs[i].e_wb_dst});
                check($sformatf("v%0d_wb_data", i), {32'd0, wb_data}, {32'd0, vecs[i].e_wb_data});
            end
        end
        check("tbl_stall_cnt", {48'd0, stall_cnt}, 64'd0);

        // Store with three wait cycles
        drive(1'b0, 5'd0, 1'b0, 1'b1, 2'b00, 32'h80, 32'h1234, 32'h0, 1'b0);
        mem_ready = 1'b0;
        tick();
        drive(1'b1, 5'd9, 1'b0, 1'b0, 2'b00, 32'h33, 32'h0, 32'h0, 1'b0);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("st_stall%0d", k), {63'd0, mem_stall}, 64'd1);
            check($sformatf("st_we%0d", k),    {63'd0, mem_we},    64'd1);
            check($sformatf("st_addr%0d", k),  {32'd0, mem_addr},  64'h80);
            check($sformatf("st_wdata%0d", k), {32'd0, mem_wdata}, 64'h1234);
            tick();
            check($sformatf("st_bubble%0d", k), {63'd0, wb_regwr}, 64'd0);
        end
        mem_ready = 1'b1;
        #1;
        check("st_release", {63'd0, mem_stall}, 64'd0);
        tick();
        check("st_em_regwr",  {63'd0, em_regwr},  64'd1);
        check("st_em_dst",    {59'd0, em_dst},    64'd9);
        check("st_wb_regwr",  {63'd0, wb_regwr},  64'd0);
        check("st_req",       {63'd0, mem_req},   64'd0);
        check("st_stall_cnt", {48'd0, stall_cnt}, 64'd3);

        // Load with two wait cycles
        drive(1'b1, 5'd12, 1'b1, 1'b0, 2'b01, 32'h44, 32'h0, 32'h0, 1'b0);
        tick();
        check("ld_wb_add_regwr", {63'd0, wb_regwr}, 64'd1);
        check("ld_wb_add_data",  {32'd0, wb_data},  64'h33);
        drive_nop();
        mem_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            check($sformatf("ld_bubble%0d", k), {63'd0, wb_regwr}, 64'd0);
        end
        mem_ready = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        tick();
        check("ld_wb_regwr",  {63'd0, wb_regwr},  64'd1);
        check("ld_wb_dst",    {59'd0, wb_dst},    64'd12);
        check("ld_wb_data",   {32'd0, wb_data},   64'hCAFEF00D);
        check("ld_stall_cnt", {48'd0, stall_cnt}, 64'd5);

        // Flush held during a stall: EX/MEM holds, then captures a bubble
        drive(1'b1, 5'd10, 1'b1, 1'b0, 2'b01, 32'h90, 32'h0, 32'h0, 1'b0);
        mem_ready = 1'b0;
        tick();
        drive(1'b1, 5'd11, 1'b0, 1'b0, 2'b00, 32'h11, 32'h0, 32'h0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            tick();
            check($sformatf("fl_hold_dst%0d", k),   {59'd0, em_dst},   64'd10);
            check($sformatf("fl_hold_regwr%0d", k), {63'd0, em_regwr}, 64'd1);
        end
        mem_ready = 1'b1;
        mem_rdata = 32'h5555AAAA;
        tick();
        check("fl_em_regwr",  {63'd0, em_regwr},  64'd0);
        check("fl_req",       {63'd0, mem_req},   64'd0);
        check("fl_wb_dst",    {59'd0, wb_dst},    64'd10);
        check("fl_wb_data",   {32'd0, wb_data},   64'h5555AAAA);
        check("fl_stall_cnt", {48'd0, stall_cnt}, 64'd7);
        drive_nop();

        // Reset arriving in WAIT abandons the access immediately
        drive(1'b1, 5'd4, 1'b1, 1'b0, 2'b01, 32'h44, 32'h0, 32'h0, 1'b0);
        mem_ready = 1'b0;
        tick();
        drive_nop();
        tick();
        check("rw_state_wait", {63'd0, dut.u_fsm.state}, {63'd0, WAIT});
        check("rw_req_before", {63'd0, mem_req},         64'd1);
        reset = 1'b1;
        #1;
        check("rw_req",       {63'd0, mem_req},         64'd0);
        check("rw_stall",     {63'd0, mem_stall},       64'd0);
        check("rw_addr",      {32'd0, mem_addr},        64'd0);
        check("rw_em_regwr",  {63'd0, em_regwr},        64'd0);
        check("rw_stall_cnt", {48'd0, stall_cnt},       64'd0);
        check("rw_state",     {63'd0, dut.u_fsm.state}, {63'd0, IDLE});
        tick();
        reset = 1'b0;
        #1;
        check("rw_state_after", {63'd0, dut.u_fsm.state}, {63'd0, IDLE});

        // Stall counter saturation
        drive(1'b1, 5'd2, 1'b1, 1'b0, 2'b01, 32'h100, 32'h0, 32'h0, 1'b0);
        tick();
        drive_nop();
        repeat (70000) @(posedge clk);
        #1;
        check("sat_stall",     {63'd0, mem_stall}, 64'd1);
        check("sat_stall_cnt", {48'd0, stall_cnt}, 64'hFFFF);
        mem_ready = 1'b1;
        tick();
        check("sat_req",       {63'd0, mem_req},   64'd0);
        check("sat_hold_cnt",  {48'd0, stall_cnt}, 64'hFFFF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
